// File: rtl/vga_fb_arbiter.sv
// Purpose: shares one single-port 1-cycle-read framebuffer RAM between VGA tile prefetch and CPU MMIO.
// Latency: CPU request seen in IDLE -> CPU_ACK 3 cycles later, 4 when the request collides with a scan slot.
// Backpressure: the scan slot (COLUMN[3:0]==14) always owns the RAM port; the CPU waits. Macro FB_ARB_STALL_CNT_EN enables STALL_CNT.
module vga_fb_arbiter #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int H_VIS   = 640,
    parameter int V_VIS   = 480,
    parameter int COLS    = 40,
    parameter int ROWS    = 30
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [9:0]  ROW,
    input  logic [9:0]  COLUMN,
    output logic [2:0]  RED,
    output logic [2:0]  GREEN,
    output logic [1:0]  BLUE,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [10:0] CPU_ADDR,
    input  logic [7:0]  CPU_WDATA,
    output logic [7:0]  CPU_RDATA,
    output logic        CPU_ACK,
    output logic [10:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic [15:0] STALL_CNT
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    localparam logic [10:0] DEPTH = 11'(COLS * ROWS);

    state_t      state, state_nxt;
    logic [7:0]  cur_tile, nxt_tile, cpu_rdata_q, fetched;
    logic        slot, fetch_ok, slot_d, fetch_d, cpu_in_range, visible;
    logic [9:0]  r2, c2;
    logic [10:0] scan_addr;

    assign slot         = (COLUMN[3:0] == 4'd14);
    assign cpu_in_range = (CPU_ADDR < DEPTH);
    assign visible      = (ROW < 10'(V_VIS)) && (COLUMN < 10'(H_VIS));
    assign fetched      = fetch_d ? MEM_RDATA : 8'd0;

    assign {RED, GREEN, BLUE} = visible ? cur_tile : 8'd0;
    assign CPU_ACK   = (state == ACK);
    assign CPU_RDATA = cpu_rdata_q;

    // Look-ahead pixel two columns ahead (wrapping line/frame) and the tile it falls in.
    always_comb begin
        c2 = COLUMN + 10'd2;
        r2 = ROW;
        if (c2 >= 10'(H_TOTAL)) begin
            c2 = c2 - 10'(H_TOTAL);
            r2 = (ROW == 10'(V_TOTAL - 1)) ? 10'd0 : ROW + 10'd1;
        end
        fetch_ok  = slot && (ROW < 10'(V_TOTAL)) && (COLUMN < 10'(H_TOTAL))
                    && (r2 < 10'(V_VIS)) && (c2 < 10'(H_VIS));
        scan_addr = 11'(r2[9:4]) * 11'(COLS) + 11'(c2[9:4]);
    end

    // RAM port mux: the scan slot wins; the CPU drives the port only in ISSUE outside a slot.
    always_comb begin
        MEM_ADDR  = 11'd0;
        MEM_WE    = 1'b0;
        MEM_WDATA = 8'd0;
        if (slot) begin
            if (fetch_ok) MEM_ADDR = scan_addr;
        end else if (state == ISSUE) begin
            MEM_ADDR = CPU_ADDR;
            if (cpu_in_range) begin
                MEM_WE    = CPU_WE;
                MEM_WDATA = CPU_WDATA;
            end
        end
    end

    // CPU handshake FSM next state. ISSUE also waits out a slot so a CPU access is never
    // displaced by a prefetch (a request seen at COLUMN[3:0]==13 would otherwise land on one).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CPU_REQ && !slot) state_nxt = ISSUE;
            ISSUE:   if (!slot) state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, tile prefetch pipeline and captured CPU read data.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            cur_tile    <= 8'd0;
            nxt_tile    <= 8'd0;
            cpu_rdata_q <= 8'd0;
            slot_d      <= 1'b0;
            fetch_d     <= 1'b0;
        end else begin
            state   <= state_nxt;
            slot_d  <= slot;
            fetch_d <= fetch_ok;
            if (slot_d) nxt_tile <= fetched;
            // The slot's data returns on the same edge the tile switches, so bypass it in.
            if (COLUMN[3:0] == 4'd15) cur_tile <= slot_d ? fetched : nxt_tile;
            if (state == CAPTURE) cpu_rdata_q <= (!CPU_WE && cpu_in_range) ? MEM_RDATA : 8'd0;
        end
    end

`ifdef FB_ARB_STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt;

    assign stall     = (state == IDLE) && CPU_REQ && slot;
    assign STALL_CNT = stall_cnt;

    // Saturating count of CPU cycles held off by a scan slot.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign STALL_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: acts as vga_driver, CPU and framebuffer RAM.
// Directed vector table plus hand sequences, then random CPU traffic and a scanout sweep
// checked against a tile-array model of what the screen should show.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  row, col;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic [7:0]  rgb;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [15:0] stall_cnt;
    logic        ram_clr;

    logic [7:0]  ram    [0:2047];
    logic [7:0]  shadow [0:1199];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [9:0]  start_col;
        logic [7:0]  exp_rdata;
        int          exp_lat;
        logic        exp_we;
    } vec_t;

    vec_t vecs [12];

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    // Framebuffer RAM: single port, one-cycle read.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 8'd0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    vga_fb_arbiter dut (
        .CLK(clk), .RST_N(rst_n), .ROW(row), .COLUMN(col),
        .RED(red), .GREEN(green), .BLUE(blue),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_RDATA(cpu_rdata), .CPU_ACK(cpu_ack),
        .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
        .STALL_CNT(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs move 1 time unit after the edge, outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        if (col == 10'd799) begin
            col = 10'd0;
            row = (row == 10'd524) ? 10'd0 : row + 10'd1;
        end else begin
            col = col + 10'd1;
        end
        #1;
    endtask

    task automatic set_pos(input int r, input int c);
        row = 10'(r);
        col = 10'(c);
        #1;
    endtask

    function automatic logic [7:0] exp_read(input logic [10:0] a);
        return (a < 11'd1200) ? shadow[a] : 8'd0;
    endfunction

    // A request met by a slot, or whose access cycle would be a slot, costs one extra cycle.
    function automatic int exp_lat(input logic [9:0] c);
        return ((c[3:0] == 4'd13) || (c[3:0] == 4'd14)) ? 4 : 3;
    endfunction

    function automatic logic [15:0] exp_stall_val();
`ifdef FB_ARB_STALL_CNT_EN
        return 16'(exp_stall);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_write(input logic we, input logic [10:0] a, input logic [7:0] d);
        if (we && (a < 11'd1200)) shadow[a] = d;
    endtask

    task automatic wait_ack(output int lat, output logic [7:0] rd, output logic we_seen);
        lat = 0;
        rd = 8'd0;
        we_seen = mem_we;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (mem_we) we_seen = 1'b1;
            if (cpu_ack) begin
                lat = n;
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        check("ack_seen", (lat != 0), 1);
        tick();
    endtask

    task automatic cpu_txn(input logic we, input logic [10:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output logic we_seen);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        wait_ack(lat, rd, we_seen);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] rd;
        logic we_seen;
        logic [9:0] start;
        logic r_we;
        logic [10:0] r_addr;
        logic [7:0] r_wd;
        logic [7:0] exp_px;
        int ack_cnt;

        vecs[0]  = '{1'b1, 11'd41,   8'hE3, 10'd100, 8'h00, 3, 1'b1};
        vecs[1]  = '{1'b0, 11'd41,   8'h00, 10'd200, 8'hE3, 3, 1'b0};
        vecs[2]  = '{1'b1, 11'd0,    8'h1C, 10'd300, 8'h00, 3, 1'b1};
        vecs[3]  = '{1'b0, 11'd0,    8'h00, 10'd2,   8'h1C, 3, 1'b0};
        vecs[4]  = '{1'b1, 11'd1200, 8'h55, 10'd400, 8'h00, 3, 1'b0};
        vecs[5]  = '{1'b0, 11'd1200, 8'h00, 10'd401, 8'h00, 3, 1'b0};
        vecs[6]  = '{1'b0, 11'd2047, 8'h00, 10'd500, 8'h00, 3, 1'b0};
        vecs[7]  = '{1'b1, 11'd1199, 8'hA5, 10'd600, 8'h00, 3, 1'b1};
        vecs[8]  = '{1'b0, 11'd1199, 8'h00, 10'd610, 8'hA5, 3, 1'b0};
        vecs[9]  = '{1'b0, 11'd41,   8'h00, 10'd46,  8'hE3, 4, 1'b0};
        vecs[10] = '{1'b1, 11'd42,   8'h77, 10'd45,  8'h00, 4, 1'b1};
        vecs[11] = '{1'b0, 11'd42,   8'h00, 10'd12,  8'h77, 3, 1'b0};

        rst_n = 1'b0;
        ram_clr = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 11'd0;
        cpu_wdata = 8'd0;
        row = 10'd0;
        col = 10'd0;
        for (int i = 0; i < 1200; i++) shadow[i] = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
        ram_clr = 1'b0;
        set_pos(0, 100);
        check("rst_ack", cpu_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rgb", rgb, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_rdata", cpu_rdata, 0);

        // Directed CPU transactions from the vector table.
        for (int v = 0; v < 12; v++) begin
            set_pos(100, int'(vecs[v].start_col));
            cpu_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd, we_seen);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_mem_we", v), we_seen, vecs[v].exp_we);
            if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            if (vecs[v].start_col[3:0] == 4'd14) exp_stall++;
            model_write(vecs[v].we, vecs[v].addr, vecs[v].wdata);
        end
        check("table_stall", stall_cnt, exp_stall_val());

        // Scanout of tile 41 (row 1, col 1) and tile 42 next to it.
        set_pos(16, 10);
        repeat (6) tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan41_c%0d", col), rgb, 8'hE3);
            tick();
        end
        check("scan42_c32", rgb, 8'h77);
        set_pos(16, 630);
        repeat (10) tick();
        check("scan_c640_blank", rgb, 0);

        // Line and frame wrap: tile 0 prefetched at ROW=524 COL=798.
        set_pos(524, 790);
        check("wrap_row524_blank", rgb, 0);
        repeat (10) tick();
        check("wrap_pos", {row, col}, {10'd0, 10'd0});
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_tile0_c%0d", col), rgb, 8'h1C);
            tick();
        end

        // Last tile row: tile 1160 fetched at end of line 463, tile 1161 at ROW=464 COL=14.
        set_pos(463, 798);
        check("fetch1160_addr", mem_addr, 11'd1160);
        check("fetch1160_we", mem_we, 0);
        set_pos(464, 14);
        check("fetch1161_addr", mem_addr, 11'd1161);

        // Collision: request rises in a scan slot at ROW=16 COL=30 (look-ahead tile 42).
        set_pos(16, 30);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 11'd41;
        #1;
        check("coll_scan_addr", mem_addr, 11'd42);
        check("coll_scan_we", mem_we, 0);
        wait_ack(lat, rd, we_seen);
        exp_stall++;
        check("coll_lat", lat, 4);
        check("coll_rdata", rd, 8'hE3);
        check("coll_stall", stall_cnt, exp_stall_val());

        // Reset during CAPTURE of a write: no ACK, but the write already in RAM stands.
        set_pos(100, 100);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 11'd500;
        cpu_wdata = 8'h99;
        #1;
        tick();
        check("mid_rst_issue_we", mem_we, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_ack) ack_cnt++;
            tick();
        end
        check("mid_rst_no_ack", ack_cnt, 0);
        check("mid_rst_stall", stall_cnt, 0);
        exp_stall = 0;
        model_write(1'b1, 11'd500, 8'h99);
        cpu_txn(1'b0, 11'd500, 8'h00, lat, rd, we_seen);
        check("mid_rst_readback", rd, 8'h99);

        // Random CPU traffic with the raster free-running.
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 20)) tick();
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) r_addr = 11'($urandom_range(0, 79));
            else r_addr = 11'($urandom_range(0, 2047));
            r_wd = 8'($urandom);
            start = col;
            cpu_txn(r_we, r_addr, r_wd, lat, rd, we_seen);
            check("rnd_lat", lat, exp_lat(start));
            if (!r_we) check("rnd_rdata", rd, exp_read(r_addr));
            if (start[3:0] == 4'd14) exp_stall++;
            model_write(r_we, r_addr, r_wd);
        end
        check("rnd_stall", stall_cnt, exp_stall_val());

        // Scanout sweep over tile rows 0-1 against the tile model.
        set_pos(524, 700);
        repeat (100) tick();
        check("sweep_start", {row, col}, {10'd0, 10'd0});
        for (int k = 0; k < 32 * 800; k++) begin
            if ((row < 10'd480) && (col < 10'd640))
                exp_px = shadow[(int'(row) / 16) * 40 + int'(col) / 16];
            else
                exp_px = 8'd0;
            check("sweep_rgb", rgb, exp_px);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
